// File: rtl/cmd_reply_pkg.sv
// Shared constants and types for the control-link response transmitter.
// Frame layout: marker, sub, LEN(2), status, payload, checksum.
package cmd_reply_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_PAY,
        ST_SUM,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_ACK,
        KIND_RATE,
        KIND_IP
    } kind_e;

    localparam logic [7:0]  RSP_MARK   = 8'h84;
    localparam logic [7:0]  SUB_RATE   = 8'h05;
    localparam logic [7:0]  SUB_GBE_IP = 8'h06;
    localparam logic [15:0] LEN_ACK    = 16'd1;
    localparam logic [15:0] LEN_DATA   = 16'd17;
    localparam logic [4:0]  HDR_BYTES  = 5'd5;

endpackage

// File: rtl/cmd_reply_tx_arb.sv
// Pending-request flags, ACK field latch and fixed-priority select.
// A set in the same cycle as a clear wins, so no request is lost.
module reply_arb
    import cmd_reply_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ack_req_i,
    input  logic [7:0] ack_sub_i,
    input  logic [7:0] ack_status_i,
    input  logic       rate_req_i,
    input  logic       ip_req_i,
    input  logic       clr_i,
    input  kind_e      clr_kind_i,
    output logic       pend_any_o,
    output kind_e      sel_kind_o,
    output logic [7:0] ack_sub_o,
    output logic [7:0] ack_status_o
);

    logic       ack_q, ack_d;
    logic       rate_q, rate_d;
    logic       ip_q, ip_d;
    logic [7:0] sub_q, sub_d;
    logic [7:0] st_q, st_d;

    always_comb begin
        ack_d  = ack_req_i
               | (ack_q & ~(clr_i && clr_kind_i == KIND_ACK));
        rate_d = rate_req_i
               | (rate_q & ~(clr_i && clr_kind_i == KIND_RATE));
        ip_d   = ip_req_i
               | (ip_q & ~(clr_i && clr_kind_i == KIND_IP));
        sub_d  = ack_req_i ? ack_sub_i : sub_q;
        st_d   = ack_req_i ? ack_status_i : st_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            rate_q <= 1'b0;
            ip_q   <= 1'b0;
            sub_q  <= 8'h00;
            st_q   <= 8'h00;
        end else begin
            ack_q  <= ack_d;
            rate_q <= rate_d;
            ip_q   <= ip_d;
            sub_q  <= sub_d;
            st_q   <= st_d;
        end
    end

    always_comb begin
        sel_kind_o = KIND_NONE;
        if (ack_q)       sel_kind_o = KIND_ACK;
        else if (rate_q) sel_kind_o = KIND_RATE;
        else if (ip_q)   sel_kind_o = KIND_IP;
    end

    assign pend_any_o   = ack_q | rate_q | ip_q;
    assign ack_sub_o    = sub_q;
    assign ack_status_o = st_q;

endmodule

// File: rtl/cmd_reply_tx.sv
// Response frame builder: snapshots ACK/RATE/IP data and streams a
// checksummed frame byte-serially under ready/valid backpressure.
module cmd_reply_tx
    import cmd_reply_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ack_req,
    input  logic [7:0]  ack_sub,
    input  logic [7:0]  ack_status,
    input  logic        rate_req,
    input  logic [31:0] rate0,
    input  logic [31:0] rate1,
    input  logic [31:0] rate2,
    input  logic [31:0] rate3,
    input  logic        ip_req,
    input  logic [31:0] sfp1_ip,
    input  logic [31:0] sfp2_ip,
    input  logic [31:0] sfp3_ip,
    input  logic [31:0] sfp4_ip,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_ready,
    output logic        busy
);

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic [127:0]  shift_q, shift_d;
    logic [7:0]    sub_q, sub_d;
    logic [7:0]    status_q, status_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    data_q, data_d;
    logic          en_q, en_d;

    logic          pend_any;
    kind_e         sel_kind;
    logic [7:0]    ack_sub_l;
    logic [7:0]    ack_status_l;
    logic          xfer;

    assign xfer = en_q & tx_ready;

    reply_arb u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .ack_req_i    (ack_req),
        .ack_sub_i    (ack_sub),
        .ack_status_i (ack_status),
        .rate_req_i   (rate_req),
        .ip_req_i     (ip_req),
        .clr_i        (state_q == ST_LOAD),
        .clr_kind_i   (kind_q),
        .pend_any_o   (pend_any),
        .sel_kind_o   (sel_kind),
        .ack_sub_o    (ack_sub_l),
        .ack_status_o (ack_status_l)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            kind_q   <= KIND_NONE;
            cnt_q    <= 5'd0;
            sum_q    <= 8'h00;
            shift_q  <= '0;
            sub_q    <= 8'h00;
            status_q <= 8'h00;
            len_q    <= 16'h0000;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            shift_q  <= shift_d;
            sub_q    <= sub_d;
            status_q <= status_d;
            len_q    <= len_d;
            data_q   <= data_d;
            en_q     <= en_d;
        end
    end

    // cnt_q indexes the byte currently presented on tx_data
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pend_any) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_HDR;
            ST_HDR: begin
                if (xfer && cnt_q == HDR_BYTES - 5'd1)
                    state_d = (len_q == LEN_ACK) ? ST_SUM : ST_PAY;
            end
            ST_PAY: begin
                if (xfer && cnt_q == len_q[4:0] + 5'd3)
                    state_d = ST_SUM;
            end
            ST_SUM:  if (xfer) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        shift_d  = shift_q;
        sub_d    = sub_q;
        status_d = status_q;
        len_d    = len_q;
        data_d   = data_q;
        en_d     = en_q;
        if (state_q == ST_IDLE) begin
            kind_d = sel_kind;
            en_d   = 1'b0;
        end else if (state_q == ST_LOAD) begin
            cnt_d  = 5'd0;
            sum_d  = 8'h00;
            en_d   = 1'b1;
            data_d = RSP_MARK;
            unique case (kind_q)
                KIND_RATE: begin
                    sub_d    = SUB_RATE;
                    status_d = 8'h00;
                    len_d    = LEN_DATA;
                    shift_d  = {rate0, rate1, rate2, rate3};
                end
                KIND_IP: begin
                    sub_d    = SUB_GBE_IP;
                    status_d = 8'h00;
                    len_d    = LEN_DATA;
                    shift_d  = {sfp1_ip, sfp2_ip, sfp3_ip, sfp4_ip};
                end
                default: begin
                    sub_d    = ack_sub_l;
                    status_d = ack_status_l;
                    len_d    = LEN_ACK;
                    shift_d  = '0;
                end
            endcase
        end else if (xfer) begin
            cnt_d = cnt_q + 5'd1;
            sum_d = sum_q + data_q;
            unique case (state_d)
                ST_HDR: begin
                    unique case (cnt_d)
                        5'd1:    data_d = sub_q;
                        5'd2:    data_d = len_q[15:8];
                        5'd3:    data_d = len_q[7:0];
                        default: data_d = status_q;
                    endcase
                end
                ST_PAY: begin
                    data_d  = shift_q[127:120];
                    shift_d = {shift_q[119:0], 8'h00};
                end
                ST_SUM:  data_d = sum_q + data_q;
                default: begin
                    data_d = 8'h00;
                    en_d   = 1'b0;
                end
            endcase
        end
    end

    assign tx_data = data_q;
    assign tx_en   = en_q;
    assign busy    = (state_q != ST_IDLE) | pend_any;

endmodule

// File: tb/tb_cmd_reply_tx.sv
// Directed bench for cmd_reply_tx with a byte scoreboard.
module tb_cmd_reply_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack_req = 1'b0;
    logic [7:0]  ack_sub = 8'h00;
    logic [7:0]  ack_status = 8'h00;
    logic        rate_req = 1'b0;
    logic [31:0] rate0 = '0, rate1 = '0, rate2 = '0, rate3 = '0;
    logic        ip_req = 1'b0;
    logic [31:0] sfp1_ip = '0, sfp2_ip = '0, sfp3_ip = '0, sfp4_ip = '0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_ready = 1'b1;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic        toggle_en = 1'b0;
    logic        gap_chk = 1'b0;

    logic        stall_q = 1'b0;
    logic [7:0]  hold_q = 8'h00;
    logic        prev_en = 1'b0;
    logic        seen = 1'b0;
    int          idle_run = 0;

    cmd_reply_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ack_req    (ack_req),
        .ack_sub    (ack_sub),
        .ack_status (ack_status),
        .rate_req   (rate_req),
        .rate0      (rate0),
        .rate1      (rate1),
        .rate2      (rate2),
        .rate3      (rate3),
        .ip_req     (ip_req),
        .sfp1_ip    (sfp1_ip),
        .sfp2_ip    (sfp2_ip),
        .sfp3_ip    (sfp3_ip),
        .sfp4_ip    (sfp4_ip),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] sub, input logic [7:0] st,
                              input logic [127:0] pay, input int n);
        logic [7:0] b[$];
        logic [7:0] s;
        b.push_back(8'h84);
        b.push_back(sub);
        b.push_back(8'h00);
        b.push_back(8'(1 + n));
        b.push_back(st);
        for (int i = 0; i < n; i++)
            b.push_back(pay[127 - 8*i -: 8]);
        s = 8'h00;
        foreach (b[i]) s = s + b[i];
        b.push_back(s);
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_left(input int left, input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() <= left) break;
        end
        chk(tag, k < 200, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (!busy && !tx_en && exp_q.size() == 0) break;
        end
        chk(tag, k < 400, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = toggle_en ? ~tx_ready : 1'b1;
        end
    end

    // scoreboard pop, hold-during-stall and inter-frame gap monitor
    always @(negedge clk) begin
        if (stall_q) begin
            chk("hold_en", tx_en, 1);
            chk("hold_data", tx_data, hold_q);
        end
        if (tx_en && tx_ready) begin
            chk("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("byte", tx_data, exp_q.pop_front());
        end
        if (!gap_chk) seen <= 1'b0;
        else if (tx_en && !prev_en) begin
            if (seen) chk("gap", idle_run, 3);
            seen <= 1'b1;
        end
        idle_run <= tx_en ? 0 : idle_run + 1;
        prev_en <= tx_en;
        stall_q <= tx_en && !tx_ready;
        hold_q <= tx_data;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", tx_en, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) next_cyc();

        // ACK with latency and length
        ack_req = 1'b1; ack_sub = 8'h03; ack_status = 8'h00;
        push_frame(8'h03, 8'h00, '0, 0);
        next_cyc();
        ack_req = 1'b0; ack_sub = 8'hEE; ack_status = 8'hEE;
        @(negedge clk);
        chk("ack_n1_en", tx_en, 0);
        chk("ack_n1_busy", busy, 1);
        @(negedge clk);
        chk("ack_n2_en", tx_en, 0);
        @(negedge clk);
        chk("ack_n3_en", tx_en, 1);
        chk("ack_n3_data", tx_data, 8'h84);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_en) break;
            n++;
        end
        chk("ack_len", n, 6);
        wait_idle("ack_done");

        // IP readback
        sfp1_ip = 32'hC0120820; sfp2_ip = 32'hC0120821;
        sfp3_ip = 32'hC0120822; sfp4_ip = 32'hC0120823;
        next_cyc();
        ip_req = 1'b1;
        push_frame(8'h06, 8'h00, {sfp1_ip, sfp2_ip, sfp3_ip, sfp4_ip}, 16);
        next_cyc();
        ip_req = 1'b0;
        wait_idle("ip_done");

        // RATE, all zero, with backpressure
        rate0 = '0; rate1 = '0; rate2 = '0; rate3 = '0;
        toggle_en = 1'b1;
        next_cyc();
        rate_req = 1'b1;
        push_frame(8'h05, 8'h00, '0, 16);
        next_cyc();
        rate_req = 1'b0;
        wait_idle("rate_stall_done");
        toggle_en = 1'b0;
        repeat (2) next_cyc();

        // simultaneous requests: priority and 3-cycle gaps
        ack_sub = 8'h10; ack_status = 8'h01;
        rate0 = 32'h01020304; rate1 = 32'hA0B0C0D0;
        rate2 = 32'hFFFFFFFF; rate3 = 32'h00000080;
        sfp1_ip = 32'h0A000001; sfp2_ip = 32'h0A000002;
        sfp3_ip = 32'hAC100001; sfp4_ip = 32'hC0A80164;
        gap_chk = 1'b1;
        next_cyc();
        ack_req = 1'b1; rate_req = 1'b1; ip_req = 1'b1;
        push_frame(8'h10, 8'h01, '0, 0);
        push_frame(8'h05, 8'h00, {rate0, rate1, rate2, rate3}, 16);
        push_frame(8'h06, 8'h00, {sfp1_ip, sfp2_ip, sfp3_ip, sfp4_ip}, 16);
        next_cyc();
        ack_req = 1'b0; rate_req = 1'b0; ip_req = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            n++;
        end
        chk("multi_busy_fall", n < 300, 1);
        chk("multi_all_sent", exp_q.size(), 0);
        gap_chk = 1'b0;
        wait_idle("multi_done");

        // RATE resent once with fresh snapshot
        rate0 = 32'h11223344;
        next_cyc();
        rate_req = 1'b1;
        push_frame(8'h05, 8'h00, {rate0, rate1, rate2, rate3}, 16);
        next_cyc();
        rate_req = 1'b0;
        wait_left(12, "rate_b10");
        rate_req = 1'b1;
        rate0 = 32'h55667788;
        push_frame(8'h05, 8'h00, {rate0, rate1, rate2, rate3}, 16);
        next_cyc();
        rate_req = 1'b0;
        wait_idle("rate_resend_done");
        repeat (10) next_cyc();
        chk("rate_no_third", busy, 0);

        // reset mid-frame with a pending IP request
        next_cyc();
        ip_req = 1'b1;
        push_frame(8'h06, 8'h00, {sfp1_ip, sfp2_ip, sfp3_ip, sfp4_ip}, 16);
        next_cyc();
        ip_req = 1'b0;
        wait_left(17, "ip_b5");
        ip_req = 1'b1;
        next_cyc();
        ip_req = 1'b0;
        wait_left(15, "ip_b7");
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_en", tx_en, 0);
        chk("rst_async_busy", busy, 0);
        exp_q.delete();
        repeat (2) next_cyc();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_en || busy) n++;
        end
        chk("post_rst_quiet", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
